exec_stage_param: RTL and testbench

- Parametrised execute/writeback stage for the cpu15 pipeline.
- Same 16-opcode ISA as the current exec stage, generalised in data, PC and immediate widths.
- Adds a configurable branch-flush depth, a STALL hold input, and visible flag/flush status.
- Sits between decode/register-read and the register file/RAM write ports; drives P_COUNT back to fetch.

---
 rtl/exec_stage_param.sv | 159 +++++++++++++++
 tb/tb_exec_stage_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/exec_stage_param.sv
// Parametrised cpu15 execute/writeback stage with branch flush, stall hold and flag/flush status.
// Optional flushed-cycle performance counter is built only when EXEC_FLUSH_CNT_EN is defined.
module exec_stage_param #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 8,
    parameter int IMM_W       = 8,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 16
) (
    input  logic              CLK_EX,
    input  logic              RESET,
    input  logic              STALL,
    input  logic [3:0]        OP_CODE,
    input  logic [DATA_W-1:0] REG_A,
    input  logic [DATA_W-1:0] REG_B,
    input  logic [IMM_W-1:0]  OP_DATA,
    input  logic [DATA_W-1:0] RAM_OUT,
    output logic [PC_W-1:0]   P_COUNT,
    output logic [DATA_W-1:0] REG_IN,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              REG_WEN,
    output logic              RAM_WEN,
    output logic              CMP_FLAG,
    output logic              FLUSHING,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR  = 4'h4, OP_SL  = 4'h5, OP_SR  = 4'h6, OP_SRA = 4'h7,
        OP_LDL = 4'h8, OP_LDH = 4'h9, OP_CMP = 4'hA, OP_JE  = 4'hB,
        OP_JMP = 4'hC, OP_LD  = 4'hD, OP_ST  = 4'hE, OP_MOV = 4'hF
    } opcode_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS);

    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_regIn;
    logic [DATA_W-1:0] r_ramIn;
    logic              r_regWen;
    logic              r_ramWen;
    logic              r_cmpFlag;
    logic [2:0]        r_flushCtr;

    logic [PC_W-1:0]   w_pcNext;
    logic [DATA_W-1:0] w_regInNext;
    logic [DATA_W-1:0] w_ramInNext;
    logic              w_regWenNext;
    logic              w_ramWenNext;
    logic              w_flagNext;
    logic [2:0]        w_flushNext;
    logic [PC_W-1:0]   w_target;
    logic              w_inFlush;
    opcode_t           w_op;

    assign w_op      = opcode_t'(OP_CODE);
    assign w_target  = PC_W'(OP_DATA);
    assign w_inFlush = (r_flushCtr != 3'd0);

    // Next-state decode; everything holds by default and write enables drop unless an op writes.
    always_comb begin
        w_pcNext     = r_pc;
        w_regInNext  = r_regIn;
        w_ramInNext  = r_ramIn;
        w_regWenNext = 1'b0;
        w_ramWenNext = 1'b0;
        w_flagNext   = r_cmpFlag;
        w_flushNext  = r_flushCtr;
        if (!STALL) begin
            w_pcNext = r_pc + PC_W'(1);
            if (w_inFlush) begin
                w_flushNext = r_flushCtr - 3'd1;
            end else begin
                case (w_op)
                    OP_NOP: ;
                    OP_ADD: begin w_regInNext = REG_A + REG_B; w_regWenNext = 1'b1; end
                    OP_SUB: begin w_regInNext = REG_A - REG_B; w_regWenNext = 1'b1; end
                    OP_AND: begin w_regInNext = REG_A & REG_B; w_regWenNext = 1'b1; end
                    OP_OR:  begin w_regInNext = REG_A | REG_B; w_regWenNext = 1'b1; end
                    OP_SL:  begin w_regInNext = {REG_A[DATA_W-2:0], 1'b0}; w_regWenNext = 1'b1; end
                    OP_SR:  begin w_regInNext = {1'b0, REG_A[DATA_W-1:1]}; w_regWenNext = 1'b1; end
                    OP_SRA: begin
                        w_regInNext  = {REG_A[DATA_W-1], REG_A[DATA_W-1:1]};
                        w_regWenNext = 1'b1;
                    end
                    OP_LDL: begin
                        w_regInNext  = {REG_A[DATA_W-1:IMM_W], OP_DATA};
                        w_regWenNext = 1'b1;
                    end
                    OP_LDH: begin
                        w_regInNext  = {OP_DATA, REG_A[DATA_W-IMM_W-1:0]};
                        w_regWenNext = 1'b1;
                    end
                    OP_CMP: w_flagNext = (REG_A == REG_B);
                    OP_JE: begin
                        if (r_cmpFlag) begin
                            w_pcNext    = w_target;
                            w_flushNext = FLUSH_LOAD;
                        end
                    end
                    OP_JMP: begin
                        w_pcNext    = w_target;
                        w_flushNext = FLUSH_LOAD;
                    end
                    OP_LD:  begin w_regInNext = RAM_OUT; w_regWenNext = 1'b1; end
                    OP_ST:  begin w_ramInNext = REG_A; w_ramWenNext = 1'b1; end
                    OP_MOV: begin w_regInNext = REG_B; w_regWenNext = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_EX or posedge RESET) begin
        if (RESET) begin
            r_pc       <= '0;
            r_regIn    <= '0;
            r_ramIn    <= '0;
            r_regWen   <= 1'b0;
            r_ramWen   <= 1'b0;
            r_cmpFlag  <= 1'b0;
            r_flushCtr <= 3'd0;
        end else begin
            r_pc       <= w_pcNext;
            r_regIn    <= w_regInNext;
            r_ramIn    <= w_ramInNext;
            r_regWen   <= w_regWenNext;
            r_ramWen   <= w_ramWenNext;
            r_cmpFlag  <= w_flagNext;
            r_flushCtr <= w_flushNext;
        end
    end

`ifdef EXEC_FLUSH_CNT_EN
    logic [CNT_W-1:0] r_flushCnt;

    // Saturating count of unstalled cycles spent suppressing instructions.
    always_ff @(posedge CLK_EX or posedge RESET) begin
        if (RESET) begin
            r_flushCnt <= '0;
        end else if (!STALL && w_inFlush && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign FLUSH_CNT = r_flushCnt;
`else
    assign FLUSH_CNT = '0;
`endif

    assign P_COUNT  = r_pc;
    assign REG_IN   = r_regIn;
    assign RAM_IN   = r_ramIn;
    assign REG_WEN  = r_regWen;
    assign RAM_WEN  = r_ramWen;
    assign CMP_FLAG = r_cmpFlag;
    assign FLUSHING = w_inFlush;

endmodule

// File: tb/tb_exec_stage_param.sv
// Directed-vector bench for exec_stage_param at default parameters.
// Expected FLUSH_CNT follows whether EXEC_FLUSH_CNT_EN is defined for the build.
module tb_exec_stage_param;

    logic        CLK_EX;
    logic        RESET;
    logic        STALL;
    logic [3:0]  OP_CODE;
    logic [15:0] REG_A;
    logic [15:0] REG_B;
    logic [7:0]  OP_DATA;
    logic [15:0] RAM_OUT;
    logic [7:0]  P_COUNT;
    logic [15:0] REG_IN;
    logic [15:0] RAM_IN;
    logic        REG_WEN;
    logic        RAM_WEN;
    logic        CMP_FLAG;
    logic        FLUSHING;
    logic [15:0] FLUSH_CNT;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef EXEC_FLUSH_CNT_EN
    localparam logic [15:0] EXP_FLUSH_CNT = 16'd2;
`else
    localparam logic [15:0] EXP_FLUSH_CNT = 16'd0;
`endif

    exec_stage_param dut (
        .CLK_EX(CLK_EX), .RESET(RESET), .STALL(STALL), .OP_CODE(OP_CODE),
        .REG_A(REG_A), .REG_B(REG_B), .OP_DATA(OP_DATA), .RAM_OUT(RAM_OUT),
        .P_COUNT(P_COUNT), .REG_IN(REG_IN), .RAM_IN(RAM_IN), .REG_WEN(REG_WEN),
        .RAM_WEN(RAM_WEN), .CMP_FLAG(CMP_FLAG), .FLUSHING(FLUSHING), .FLUSH_CNT(FLUSH_CNT)
    );

    initial begin
        CLK_EX = 1'b0;
        forever #5 CLK_EX = ~CLK_EX;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one instruction, let one edge retire it, then sample just after the edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] imm, input logic stall);
        OP_CODE = op;
        REG_A   = a;
        REG_B   = b;
        OP_DATA = imm;
        STALL   = stall;
        @(posedge CLK_EX);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [7:0] pc, input logic [15:0] regIn,
                              input logic regWen, input logic ramWen, input logic flushing);
        checkOutput({tag, ".pc"}, 32'(P_COUNT), 32'(pc));
        checkOutput({tag, ".regIn"}, 32'(REG_IN), 32'(regIn));
        checkOutput({tag, ".regWen"}, 32'(REG_WEN), 32'(regWen));
        checkOutput({tag, ".ramWen"}, 32'(RAM_WEN), 32'(ramWen));
        checkOutput({tag, ".flushing"}, 32'(FLUSHING), 32'(flushing));
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; OP_CODE = 4'h0;
        REG_A = '0; REG_B = '0; OP_DATA = '0; RAM_OUT = 16'hCAFE;
        #12;
        checkState("reset", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.ramIn", 32'(RAM_IN), 32'h0);
        checkOutput("reset.flag", 32'(CMP_FLAG), 32'h0);
        checkOutput("reset.flushCnt", 32'(FLUSH_CNT), 32'h0);
        RESET = 1'b0;

        applyStimulus(4'h1, 16'h7FFF, 16'h0001, 8'h00, 1'b0);
        checkState("add1", 8'h01, 16'h8000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h1, 16'hFFFF, 16'h0001, 8'h00, 1'b0);
        checkState("addWrap", 8'h02, 16'h0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h2, 16'h0005, 16'h0007, 8'h00, 1'b0);
        checkState("sub", 8'h03, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h3, 16'hF0F0, 16'h3C3C, 8'h00, 1'b0);
        checkState("and", 8'h04, 16'h3030, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h4, 16'hF0F0, 16'h0F0F, 8'h00, 1'b0);
        checkState("or", 8'h05, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h5, 16'h8001, 16'h0000, 8'h00, 1'b0);
        checkState("sl", 8'h06, 16'h0002, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h6, 16'h8001, 16'h0000, 8'h00, 1'b0);
        checkState("sr", 8'h07, 16'h4000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h7, 16'h8002, 16'h0000, 8'h00, 1'b0);
        checkState("sra", 8'h08, 16'hC001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h9, 16'h1234, 16'h0000, 8'hAB, 1'b0);
        checkState("ldh", 8'h09, 16'hAB34, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'hF, 16'h0000, 16'h5A5A, 8'h00, 1'b0);
        checkState("mov", 8'h0A, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'hD, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("ld", 8'h0B, 16'hCAFE, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h0, 16'h1111, 16'h2222, 8'h00, 1'b0);
        checkState("nop", 8'h0C, 16'hCAFE, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'h40, 1'b0);
        checkState("jmp", 8'h40, 16'hCAFE, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h1, 16'h0001, 16'h0001, 8'h00, 1'b0);
        checkState("flush1", 8'h41, 16'hCAFE, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h1, 16'h0001, 16'h0001, 8'h00, 1'b0);
        checkState("flush2", 8'h42, 16'hCAFE, 1'b0, 1'b0, 1'b0);
        checkOutput("flushCnt", 32'(FLUSH_CNT), 32'(EXP_FLUSH_CNT));
        applyStimulus(4'h1, 16'h0001, 16'h0001, 8'h00, 1'b0);
        checkState("postFlushAdd", 8'h43, 16'h0002, 1'b1, 1'b0, 1'b0);

        applyStimulus(4'hA, 16'h1234, 16'h1234, 8'h00, 1'b0);
        checkState("cmpEq", 8'h44, 16'h0002, 1'b0, 1'b0, 1'b0);
        checkOutput("cmpEq.flag", 32'(CMP_FLAG), 32'h1);
        applyStimulus(4'hB, 16'h0000, 16'h0000, 8'h10, 1'b0);
        checkState("jeTaken", 8'h10, 16'h0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("jeFlushDone", 8'h12, 16'h0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hA, 16'h1234, 16'h1235, 8'h00, 1'b0);
        checkOutput("cmpNe.flag", 32'(CMP_FLAG), 32'h0);
        applyStimulus(4'hB, 16'h0000, 16'h0000, 8'h10, 1'b0);
        checkState("jeNotTaken", 8'h14, 16'h0002, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'hFF, 1'b0);
        checkState("jmpFF", 8'hFF, 16'h0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("flushWrap1", 8'h00, 16'h0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("flushWrap2", 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'hFC, 1'b0);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("pcAtFF", 8'hFF, 16'h0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("normalWrap", 8'h00, 16'h0002, 1'b0, 1'b0, 1'b0);

        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'h20, 1'b0);
        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'h80, 1'b0);
        checkState("jmpInFlush", 8'h21, 16'h0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'h0, 16'h0000, 16'h0000, 8'h00, 1'b0);
        checkState("afterDiscard", 8'h22, 16'h0002, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'hE, 16'hBEEF, 16'h0000, 8'h00, 1'b1);
            checkState($sformatf("stStall%0d", i), 8'h22, 16'h0002, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("stStall%0d.ramIn", i), 32'(RAM_IN), 32'h0);
        end
        applyStimulus(4'hE, 16'hBEEF, 16'h0000, 8'h00, 1'b0);
        checkState("st", 8'h23, 16'h0002, 1'b0, 1'b1, 1'b0);
        checkOutput("st.ramIn", 32'(RAM_IN), 32'hBEEF);
        applyStimulus(4'h1, 16'h0003, 16'h0004, 8'h00, 1'b1);
        checkState("stallAfterSt", 8'h23, 16'h0002, 1'b0, 1'b0, 1'b0);
        checkOutput("stallAfterSt.ramIn", 32'(RAM_IN), 32'hBEEF);

        applyStimulus(4'hC, 16'h0000, 16'h0000, 8'h30, 1'b0);
        checkState("jmpBeforeReset", 8'h30, 16'h0002, 1'b0, 1'b0, 1'b1);
        #1 RESET = 1'b1;
        #1;
        checkState("asyncReset", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("asyncReset.ramIn", 32'(RAM_IN), 32'h0);
        checkOutput("asyncReset.flag", 32'(CMP_FLAG), 32'h0);
        checkOutput("asyncReset.flushCnt", 32'(FLUSH_CNT), 32'h0);
        #1 RESET = 1'b0;
        applyStimulus(4'h8, 16'h1200, 16'h0000, 8'hAB, 1'b0);
        checkState("ldlAfterReset", 8'h01, 16'h12AB, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
